// File: rtl/spi_reg_bridge_if.sv
// Byte-level link between the SPI slave shifter and the register bridge.
// The shifter side is the master; the bridge is the slave.
interface spi_reg_bridge_if;
    logic       ss;        // chip select, active low
    logic [7:0] rx_byte;   // received byte from the shifter
    logic       rx_valid;  // 1-cycle strobe qualifying rx_byte
    logic [7:0] tx_byte;   // next byte for the shifter to send

    modport master (
        output ss,
        output rx_byte,
        output rx_valid,
        input  tx_byte
    );

    modport slave (
        input  ss,
        input  rx_byte,
        input  rx_valid,
        output tx_byte
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI command decoder and 8-bit register bank.
// Each chip-select frame is one command byte (bit7 = read, bits 6:0 = start address)
// followed by a data burst with 7-bit address auto-increment.
// A hardware port reads the bank combinationally and can write it in any state.
module spi_reg_bridge #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  RESET_VAL = 8'h00,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_reg_bridge_if.slave        spi,
    input  logic [6:0]             hw_raddr,
    output logic [7:0]             hw_rdata,
    input  logic                   hw_we,
    input  logic [6:0]             hw_waddr,
    input  logic [7:0]             hw_wdata,
    output logic                   wr_pulse,
    output logic [6:0]             wr_addr,
    output logic                   addr_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RD   = 2'd3;

    logic [1:0] r_state;
    logic [6:0] r_addr;
    logic [7:0] r_regs [DEPTH];
    logic [7:0] r_tx;
    logic       r_wr_pulse;
    logic [6:0] r_wr_addr;
    logic       r_addr_err;

    logic [6:0] w_addr_inc;
    logic       w_addr_ok;
    logic       w_inc_ok;
    logic       w_cmd_ok;
    logic       w_spi_we;

    // Addresses at or above DEPTH are unimplemented; compare at 8 bits so DEPTH = 128 works.
    function automatic logic f_in_range(input logic [6:0] a);
        return ({1'b0, a} < 8'(DEPTH));
    endfunction

    // Explicit decode so unimplemented addresses read as zero without index truncation.
    function automatic logic [7:0] f_read(input logic [6:0] a);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (a == 7'(i)) v = r_regs[i];
        end
        return v;
    endfunction

    // Decode of the current SPI access: next address and range checks.
    always_comb begin
        w_addr_inc = r_addr + 7'd1;
        w_addr_ok  = f_in_range(r_addr);
        w_inc_ok   = f_in_range(w_addr_inc);
        w_cmd_ok   = f_in_range(spi.rx_byte[6:0]);
        w_spi_we   = (r_state == S_WR) && !spi.ss && spi.rx_valid && w_addr_ok;
    end

    // Frame FSM, address pointer, transmit byte and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= 7'd0;
            r_tx       <= SYNC_BYTE;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_addr_err <= 1'b0;
        end else begin
            r_wr_pulse <= 1'b0;
            if (spi.ss) begin
                // Deselect aborts any frame; a coincident rx_valid is dropped.
                r_state <= S_IDLE;
                r_addr  <= 7'd0;
                r_tx    <= SYNC_BYTE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_CMD;
                        r_tx    <= SYNC_BYTE;
                    end
                    S_CMD: begin
                        if (spi.rx_valid) begin
                            r_addr <= spi.rx_byte[6:0];
                            if (spi.rx_byte[7]) begin
                                r_state <= S_RD;
                                r_tx    <= f_read(spi.rx_byte[6:0]);
                                if (!w_cmd_ok) r_addr_err <= 1'b1;
                            end else begin
                                r_state <= S_WR;
                            end
                        end
                    end
                    S_WR: begin
                        if (spi.rx_valid) begin
                            if (w_addr_ok) begin
                                r_wr_pulse <= 1'b1;
                                r_wr_addr  <= r_addr;
                            end else begin
                                r_addr_err <= 1'b1;
                            end
                            r_addr <= w_addr_inc;
                        end
                    end
                    default: begin
                        if (spi.rx_valid) begin
                            r_addr <= w_addr_inc;
                            r_tx   <= f_read(w_addr_inc);
                            if (!w_inc_ok) r_addr_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Register bank; the SPI write is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hw_we && hw_waddr == 7'(i)) r_regs[i] <= hw_wdata;
                if (w_spi_we && r_addr == 7'(i)) r_regs[i] <= spi.rx_byte;
            end
        end
    end

    assign hw_rdata    = f_read(hw_raddr);
    assign spi.tx_byte = r_tx;
    assign wr_pulse    = r_wr_pulse;
    assign wr_addr     = r_wr_addr;
    assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge (DEPTH = 16, RESET_VAL = 0, SYNC_BYTE = A5).
module tb_spi_reg_bridge;

    logic       clk;
    logic       rst;
    logic [6:0] hw_raddr;
    logic [7:0] hw_rdata;
    logic       hw_we;
    logic [6:0] hw_waddr;
    logic [7:0] hw_wdata;
    logic       wr_pulse;
    logic [6:0] wr_addr;
    logic       addr_err;
    logic [7:0] rdv;
    int         total;
    int         bad;

    spi_reg_bridge_if u_if ();

    spi_reg_bridge #(
        .DEPTH     (16),
        .RESET_VAL (8'h00),
        .SYNC_BYTE (8'hA5)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .spi      (u_if.slave),
        .hw_raddr (hw_raddr),
        .hw_rdata (hw_rdata),
        .hw_we    (hw_we),
        .hw_waddr (hw_waddr),
        .hw_wdata (hw_wdata),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        u_if.rx_byte  = b;
        u_if.rx_valid = 1'b1;
        tick();
        u_if.rx_valid = 1'b0;
    endtask

    task automatic frame_start();
        u_if.ss = 1'b0;
        tick();
    endtask

    task automatic frame_end();
        u_if.ss = 1'b1;
        tick();
        tick();
    endtask

    task automatic rd(input logic [6:0] a);
        hw_raddr = a;
        #1;
        rdv = hw_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (u_if.tx_byte !== 8'hA5) begin bad++; $display("FAIL reset_tx: got %h want a5", u_if.tx_byte); end
        total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", wr_pulse); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", addr_err); end
        total++; if (wr_addr !== 7'd0) begin bad++; $display("FAIL reset_wraddr: got %h want 0", wr_addr); end
        rd(7'd5);
        total++; if (rdv !== 8'h00) begin bad++; $display("FAIL reset_reg5: got %h want 00", rdv); end
    endtask

    task automatic test_write_burst();
        frame_start();
        send(8'h03);
        total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL wb_cmd_pulse: got %b want 0", wr_pulse); end
        send(8'h11);
        total++; if (wr_pulse !== 1'b1 || wr_addr !== 7'd3) begin bad++; $display("FAIL wb_p1: got %b/%h want 1/03", wr_pulse, wr_addr); end
        tick();
        total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL wb_pulse_width: got %b want 0", wr_pulse); end
        send(8'h22);
        total++; if (wr_pulse !== 1'b1 || wr_addr !== 7'd4) begin bad++; $display("FAIL wb_p2: got %b/%h want 1/04", wr_pulse, wr_addr); end
        send(8'h33);
        total++; if (wr_pulse !== 1'b1 || wr_addr !== 7'd5) begin bad++; $display("FAIL wb_p3: got %b/%h want 1/05", wr_pulse, wr_addr); end
        frame_end();
        rd(7'd3);
        total++; if (rdv !== 8'h11) begin bad++; $display("FAIL wb_reg3: got %h want 11", rdv); end
        rd(7'd4);
        total++; if (rdv !== 8'h22) begin bad++; $display("FAIL wb_reg4: got %h want 22", rdv); end
        rd(7'd5);
        total++; if (rdv !== 8'h33) begin bad++; $display("FAIL wb_reg5: got %h want 33", rdv); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL wb_err: got %b want 0", addr_err); end
    endtask

    task automatic test_read_burst();
        hw_we = 1'b1; hw_waddr = 7'd6; hw_wdata = 8'h5A;
        tick();
        hw_waddr = 7'd7; hw_wdata = 8'hC3;
        tick();
        hw_we = 1'b0;
        frame_start();
        total++; if (u_if.tx_byte !== 8'hA5) begin bad++; $display("FAIL rb_cmd_tx: got %h want a5", u_if.tx_byte); end
        send(8'h86);
        total++; if (u_if.tx_byte !== 8'h5A) begin bad++; $display("FAIL rb_tx6: got %h want 5a", u_if.tx_byte); end
        send(8'hFF);
        total++; if (u_if.tx_byte !== 8'hC3) begin bad++; $display("FAIL rb_tx7: got %h want c3", u_if.tx_byte); end
        send(8'hFF);
        total++; if (u_if.tx_byte !== 8'h00) begin bad++; $display("FAIL rb_tx8: got %h want 00", u_if.tx_byte); end
        frame_end();
        total++; if (u_if.tx_byte !== 8'hA5) begin bad++; $display("FAIL rb_idle_tx: got %h want a5", u_if.tx_byte); end
        rd(7'd7);
        total++; if (rdv !== 8'hC3) begin bad++; $display("FAIL rb_reg7_kept: got %h want c3", rdv); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL rb_err: got %b want 0", addr_err); end
    endtask

    task automatic test_out_of_range();
        frame_start();
        send(8'h0F);
        send(8'hAA);
        total++; if (wr_pulse !== 1'b1 || wr_addr !== 7'd15) begin bad++; $display("FAIL oor_p15: got %b/%h want 1/0f", wr_pulse, wr_addr); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL oor_err_early: got %b want 0", addr_err); end
        send(8'hBB);
        total++; if (wr_pulse !== 1'b0 || addr_err !== 1'b1) begin bad++; $display("FAIL oor_a16: got %b/%b want 0/1", wr_pulse, addr_err); end
        send(8'hCC);
        total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL oor_a17: got %b want 0", wr_pulse); end
        frame_end();
        rd(7'd15);
        total++; if (rdv !== 8'hAA) begin bad++; $display("FAIL oor_reg15: got %h want aa", rdv); end
        rd(7'd16);
        total++; if (rdv !== 8'h00) begin bad++; $display("FAIL oor_hw16: got %h want 00", rdv); end
        frame_start();
        send(8'h7F);
        send(8'h01);
        total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL wrap_a127: got %b want 0", wr_pulse); end
        send(8'h02);
        total++; if (wr_pulse !== 1'b1 || wr_addr !== 7'd0) begin bad++; $display("FAIL wrap_a0: got %b/%h want 1/00", wr_pulse, wr_addr); end
        frame_end();
        rd(7'd0);
        total++; if (rdv !== 8'h02) begin bad++; $display("FAIL wrap_reg0: got %h want 02", rdv); end
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", addr_err); end
    endtask

    task automatic test_abort();
        frame_start();
        send(8'h00);
        send(8'h10);
        // Deselect together with a data strobe aimed at reg1: the strobe must be dropped.
        u_if.ss = 1'b1;
        u_if.rx_byte = 8'h77;
        u_if.rx_valid = 1'b1;
        tick();
        u_if.rx_valid = 1'b0;
        total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL ab_pulse: got %b want 0", wr_pulse); end
        total++; if (u_if.tx_byte !== 8'hA5) begin bad++; $display("FAIL ab_tx: got %h want a5", u_if.tx_byte); end
        tick();
        rd(7'd0);
        total++; if (rdv !== 8'h10) begin bad++; $display("FAIL ab_reg0: got %h want 10", rdv); end
        rd(7'd1);
        total++; if (rdv !== 8'h00) begin bad++; $display("FAIL ab_reg1: got %h want 00", rdv); end
        frame_start();
        send(8'h80);
        total++; if (u_if.tx_byte !== 8'h10) begin bad++; $display("FAIL ab_reread: got %h want 10", u_if.tx_byte); end
        frame_end();
    endtask

    task automatic test_collision();
        frame_start();
        send(8'h02);
        u_if.rx_byte = 8'h44; u_if.rx_valid = 1'b1;
        hw_we = 1'b1; hw_waddr = 7'd2; hw_wdata = 8'h99;
        tick();
        u_if.rx_byte = 8'h55;
        hw_waddr = 7'd9; hw_wdata = 8'h66;
        tick();
        u_if.rx_valid = 1'b0; hw_we = 1'b0;
        frame_end();
        rd(7'd2);
        total++; if (rdv !== 8'h44) begin bad++; $display("FAIL col_reg2: got %h want 44", rdv); end
        rd(7'd3);
        total++; if (rdv !== 8'h55) begin bad++; $display("FAIL col_reg3: got %h want 55", rdv); end
        rd(7'd9);
        total++; if (rdv !== 8'h66) begin bad++; $display("FAIL col_reg9: got %h want 66", rdv); end
    endtask

    task automatic test_read_during_write();
        frame_start();
        u_if.rx_byte = 8'h89; u_if.rx_valid = 1'b1;
        hw_we = 1'b1; hw_waddr = 7'd9; hw_wdata = 8'h77;
        tick();
        u_if.rx_valid = 1'b0; hw_we = 1'b0;
        total++; if (u_if.tx_byte !== 8'h66) begin bad++; $display("FAIL rdw_tx: got %h want 66", u_if.tx_byte); end
        rd(7'd9);
        total++; if (rdv !== 8'h77) begin bad++; $display("FAIL rdw_reg9: got %h want 77", rdv); end
        frame_end();
    endtask

    task automatic test_reset_midframe();
        frame_start();
        send(8'h00);
        send(8'h01);
        send(8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (u_if.tx_byte !== 8'hA5) begin bad++; $display("FAIL rm_tx: got %h want a5", u_if.tx_byte); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL rm_err: got %b want 0", addr_err); end
        total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL rm_pulse: got %b want 0", wr_pulse); end
        rd(7'd0);
        total++; if (rdv !== 8'h00) begin bad++; $display("FAIL rm_reg0: got %h want 00", rdv); end
        rd(7'd2);
        total++; if (rdv !== 8'h00) begin bad++; $display("FAIL rm_reg2: got %h want 00", rdv); end
        rd(7'd15);
        total++; if (rdv !== 8'h00) begin bad++; $display("FAIL rm_reg15: got %h want 00", rdv); end
        frame_end();
        frame_start();
        send(8'h83);
        total++; if (u_if.tx_byte !== 8'h00) begin bad++; $display("FAIL rm_read3: got %h want 00", u_if.tx_byte); end
        frame_end();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        u_if.ss = 1'b1;
        u_if.rx_byte = 8'h00;
        u_if.rx_valid = 1'b0;
        hw_raddr = 7'd0;
        hw_we = 1'b0;
        hw_waddr = 7'd0;
        hw_wdata = 8'h00;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_out_of_range();
        test_abort();
        test_collision();
        test_read_during_write();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
